// File: rtl/jtpang_pkg.sv
// Shared definitions for the jtpang object DMA: table geometry and FSM encoding.
package jtpang_pkg;

    localparam int OBJ_AW = 9;
    localparam int OBJ_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        COPY  = 2'd2,
        FLUSH = 2'd3
    } dma_state_t;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: one write port, one registered read port, common clock.
module jtframe_dual_ram #(
    parameter int AW = 10,
    parameter int DW = 8
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/jtpang_objdma.sv
// Object-table DMA: copies 512 bytes of VRAM into a double-buffered object
// buffer while holding the CPU bus, then swaps banks on the next vertical blank.
module jtpang_objdma
    import jtpang_pkg::*;
#(
    parameter int AW = OBJ_AW,
    parameter int DW = OBJ_DW
)(
    input  logic          rst,
    input  logic          clk,
    input  logic          pxl_cen,
    input  logic          LVBL,
    input  logic          dma_go,
    output logic          busrq,
    input  logic          busak_n,
    output logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_din,
    input  logic [AW-1:0] scan_addr,
    output logic [DW-1:0] scan_dout,
    output logic          dma_busy
);

    localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};

    dma_state_t    st, st_next;
    logic          step, flush_cen, ram_we, lvbl_l, lvbl_fall;
    logic          wr_bank, swap_pend, wr_pend;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= st_next;
    end

    // NOTE: outputs of a combinational block get a default first so no path infers a latch.
    always_comb begin
        st_next = st;
        case (st)
            IDLE:    if (pxl_cen && dma_go)   st_next = REQ;
            REQ:     if (pxl_cen && !busak_n) st_next = COPY;
            COPY:    if (step && dma_addr == ADDR_LAST) st_next = FLUSH;
            FLUSH:   if (pxl_cen)             st_next = IDLE;
            default: st_next = IDLE;
        endcase
    end

    assign step      = (st == COPY) && pxl_cen && !busak_n;
    assign flush_cen = (st == FLUSH) && pxl_cen;
    assign lvbl_fall = lvbl_l && !LVBL;
    assign dma_busy  = (st != IDLE);
    // Writes trail the address by one byte: each step commits the byte captured on the previous step.
    assign ram_we    = (step && wr_pend) || flush_cen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busrq     <= 1'b0;
            dma_addr  <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_pend   <= 1'b0;
            wr_bank   <= 1'b0;
            swap_pend <= 1'b0;
            lvbl_l    <= 1'b0;
        end else begin
            busrq  <= (st_next != IDLE);
            lvbl_l <= LVBL;
            if (st == REQ && st_next == COPY) dma_addr <= '0;
            if (step) begin
                wr_addr  <= dma_addr;
                wr_data  <= dma_din;
                wr_pend  <= 1'b1;
                dma_addr <= dma_addr + AW'(1);
            end
            if (flush_cen) begin
                wr_pend   <= 1'b0;
                swap_pend <= 1'b1;
            end
            // Swaps only in IDLE, so a blank that lands mid-copy is deferred to the next one.
            if (lvbl_fall && swap_pend && st == IDLE) begin
                wr_bank   <= ~wr_bank;
                swap_pend <= 1'b0;
            end
        end
    end

    jtframe_dual_ram #(
        .AW (AW + 1),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (ram_we),
        .wr_addr ({wr_bank, wr_addr}),
        .wr_data (wr_data),
        .rd_addr ({~wr_bank, scan_addr}),
        .rd_data (scan_dout)
    );

endmodule

// File: tb/tb_jtpang_objdma.sv
// Directed bench for jtpang_objdma: VRAM model, scanner scoreboard and bus-handshake scenarios.
module tb_jtpang_objdma;

    localparam int PA = 0, PB = 1, PC = 2, PD = 3, PE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       LVBL, dma_go, busak_n;
    logic       busrq, dma_busy;
    logic [8:0] dma_addr, scan_addr;
    logic [7:0] dma_din, scan_dout;
    logic [1:0] cen_cnt = 2'd0;
    logic       pxl_cen;

    logic [7:0] vram [512];
    logic [7:0] sb_q [$];

    int n_total = 0;
    int n_pass  = 0;
    int rq_cens = 0, busy_cens = 0, rq_falls = 0;
    logic busrq_d = 1'b0;

    jtpang_objdma dut (
        .rst       (rst),
        .clk       (clk),
        .pxl_cen   (pxl_cen),
        .LVBL      (LVBL),
        .dma_go    (dma_go),
        .busrq     (busrq),
        .busak_n   (busak_n),
        .dma_addr  (dma_addr),
        .dma_din   (dma_din),
        .scan_addr (scan_addr),
        .scan_dout (scan_dout),
        .dma_busy  (dma_busy)
    );

    always #5 clk = ~clk;

    // Pixel enable on every fourth clock.
    always @(posedge clk) cen_cnt <= cen_cnt + 2'd1;
    assign pxl_cen = (cen_cnt == 2'd3);

    // VRAM with one clock of read latency.
    always @(posedge clk) dma_din <= vram[dma_addr];

    always @(negedge clk) begin
        if (busrq && pxl_cen)    rq_cens++;
        if (dma_busy && pxl_cen) busy_cens++;
        if (busrq_d && !busrq)   rq_falls++;
        busrq_d = busrq;
    end

    function automatic logic [7:0] pat(input int k, input int i);
        case (k)
            PA:      pat = 8'(i) ^ 8'h5A;
            PB:      pat = 8'(i * 37 + 11);
            PC:      pat = 8'(i * 3) ^ 8'h3C;
            PD:      pat = 8'(i * 13) ^ 8'hC6;
            default: pat = ~8'(i * 37 + 11);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill(input int k);
        for (int i = 0; i < 512; i++) vram[i] = pat(k, i);
    endtask

    task automatic clear_mon();
        tick(2);
        rq_cens = 0; busy_cens = 0; rq_falls = 0;
    endtask

    task automatic scan_check(input int addr, input logic [7:0] exp, input string tag);
        scan_addr = 9'(addr);
        sb_q.push_back(exp);
        @(negedge clk);
        check(tag, 32'(scan_dout), 32'(sb_q.pop_front()));
    endtask

    task automatic scan_sweep(input int k, input string tag);
        for (int i = 0; i < 512; i++) scan_check(i, pat(k, i), $sformatf("%s[%0d]", tag, i));
    endtask

    task automatic pulse_go();
        int k = 0;
        @(negedge clk);
        while (!pxl_cen && k < 8) begin @(negedge clk); k++; end
        dma_go = 1'b1;
        @(negedge clk);
        dma_go = 1'b0;
    endtask

    task automatic start_copy(input string tag);
        pulse_go();
        check({tag, "_busrq_set"}, 32'(busrq), 32'd1);
        check({tag, "_busy_set"}, 32'(dma_busy), 32'd1);
        tick(2);
        busak_n = 1'b0;
    endtask

    task automatic wait_addr(input int target, input string tag);
        int k = 0;
        while (dma_addr != 9'(target) && k < 5000) begin @(negedge clk); k++; end
        check(tag, 32'(dma_addr), 32'(target));
    endtask

    task automatic finish_copy(input string tag);
        int k = 0;
        while (dma_busy && k < 5000) begin @(negedge clk); k++; end
        check({tag, "_busy_clr"}, 32'(dma_busy), 32'd0);
        check({tag, "_busrq_clr"}, 32'(busrq), 32'd0);
        check({tag, "_addr_wrap"}, 32'(dma_addr), 32'd0);
        busak_n = 1'b1;
    endtask

    task automatic lvbl_fall();
        @(negedge clk);
        LVBL = 1'b0;
        tick(4);
        LVBL = 1'b1;
        tick(2);
    endtask

    initial begin
        int hold;
        rst = 1'b1; LVBL = 1'b1; dma_go = 1'b0; busak_n = 1'b1; scan_addr = '0;
        fill(PA);
        tick(3);
        check("rst_busrq", 32'(busrq), 32'd0);
        check("rst_busy", 32'(dma_busy), 32'd0);
        check("rst_addr", 32'(dma_addr), 32'd0);
        check("rst_scan", 32'(scan_dout), 32'd0);
        rst = 1'b0;
        tick(3);

        // Basic copy; the new table becomes visible at the next blank.
        clear_mon();
        start_copy("a");
        finish_copy("a");
        check("a_busrq_cens", 32'(rq_cens), 32'd514);
        lvbl_fall();
        scan_check(3, 8'h59, "a_scan3");
        scan_check(0, pat(PA, 0), "a_scan0");
        scan_check(511, pat(PA, 511), "a_scan511");

        // Bus stall at address 100, scanner isolated from the bank being filled.
        fill(PB);
        clear_mon();
        start_copy("b");
        wait_addr(100, "b_reach100");
        busak_n = 1'b1;
        hold = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (dma_addr == 9'd100 && busrq) hold++;
        end
        check("b_stall_hold", 32'(hold), 32'd80);
        busak_n = 1'b0;
        scan_sweep(PA, "b_iso");
        check("b_still_busy", 32'(dma_busy), 32'd1);
        finish_copy("b");
        check("b_busrq_cens", 32'(rq_cens), 32'd534);
        lvbl_fall();
        scan_sweep(PB, "b_table");

        // Second trigger mid-copy is dropped.
        fill(PC);
        clear_mon();
        start_copy("c");
        wait_addr(200, "c_reach200");
        pulse_go();
        finish_copy("c");
        tick(40);
        check("c_no_requeue", 32'(dma_busy), 32'd0);
        check("c_busy_cens", 32'(busy_cens), 32'd514);
        check("c_busrq_falls", 32'(rq_falls), 32'd1);

        // Swap still pending from C; blank mid-copy must not swap.
        fill(PD);
        clear_mon();
        start_copy("d");
        wait_addr(150, "d_reach150");
        lvbl_fall();
        scan_check(5, pat(PB, 5), "d_mid_old5");
        scan_check(400, pat(PB, 400), "d_mid_old400");
        finish_copy("d");
        check("d_busy_cens", 32'(busy_cens), 32'd514);
        scan_check(77, pat(PB, 77), "d_pre_swap77");
        lvbl_fall();
        scan_check(5, pat(PD, 5), "d_swap5");
        scan_check(400, pat(PD, 400), "d_swap400");
        lvbl_fall();
        scan_check(400, pat(PD, 400), "d_single_swap");

        // Reset during copy at address 300.
        fill(PE);
        start_copy("e");
        wait_addr(300, "e_reach300");
        rst = 1'b1;
        #1;
        check("e_rst_busrq", 32'(busrq), 32'd0);
        @(negedge clk);
        check("e_rst_busy", 32'(dma_busy), 32'd0);
        check("e_rst_addr", 32'(dma_addr), 32'd0);
        check("e_rst_scan", 32'(scan_dout), 32'd0);
        busak_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        scan_check(10, pat(PE, 10), "e_bank1_partial");
        scan_check(350, pat(PB, 350), "e_bank1_old");
        lvbl_fall();
        scan_check(350, pat(PB, 350), "e_no_swap350");
        scan_check(320, pat(PB, 320), "e_no_write320");
        check("e_idle_busy", 32'(dma_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jtpang_objdma.md
JTPANG_OBJDMA -- requirements
Module: jtpang_objdma

Interface
REQ-001 Parameter AW, 9: DMA and scan address width (512-byte object table).
REQ-002 Parameter DW, 8: data width of VRAM and of the object buffer.
REQ-003 Port rst, in, 1: reset, asynchronous, active-high.
REQ-004 Port clk, in, 1: single system clock; all state on its rising edge.
REQ-005 Port pxl_cen, in, 1: pixel clock enable; one DMA byte per asserted cycle.
REQ-006 Port LVBL, in, 1: vertical blank, low during blank.
REQ-007 Port dma_go, in, 1: CPU DMA trigger, sampled on pxl_cen.
REQ-008 Port busrq, out, 1: bus request to the CPU, active-high.
REQ-009 Port busak_n, in, 1: bus acknowledge from the CPU, active-low.
REQ-010 Port dma_addr, out, AW: VRAM read address during copy.
REQ-011 Port dma_din, in, DW: VRAM data; valid one clk cycle after dma_addr changes.
REQ-012 Port scan_addr, in, AW: object-scanner read address.
REQ-013 Port scan_dout, out, DW: object-scanner data; registered, one clk of latency.
REQ-014 Port dma_busy, out, 1: high from the accepted dma_go until copy end.

Function
REQ-015 FSM states: IDLE, REQ, COPY, FLUSH; reset state is IDLE.
REQ-016 IDLE: when dma_go=1 on pxl_cen, go to REQ and set busrq=1 in the same edge.
REQ-017 REQ: stay in REQ while busak_n=1; on busak_n=0 with pxl_cen, go to COPY with dma_addr=0.
REQ-018 COPY: on each pxl_cen with busak_n=0, dma_addr increments by 1.
REQ-019 COPY: dma_din is written into the write bank at the previous dma_addr.
REQ-020 COPY: if busak_n=1 on a pxl_cen, dma_addr and all writes hold; the copy resumes on the next busak_n=0.
REQ-021 COPY: when dma_addr=511 is issued, dma_addr wraps to 0 and the FSM goes to FLUSH.
REQ-022 FLUSH: on the next pxl_cen, write byte 511, clear busrq, set the pending-swap flag and return to IDLE.
REQ-023 dma_go outside IDLE is ignored; it is not queued.
REQ-024 Buffer: two banks of 2^AW x DW.
REQ-025 The DMA writes only bank wr_bank; the scanner reads only bank ~wr_bank.
REQ-026 Swap: on the LVBL falling edge, if pending-swap=1, toggle wr_bank and clear pending-swap.
REQ-027 A swap requested while state is not IDLE is deferred to the next LVBL falling edge after FLUSH completes.
REQ-028 A pending-swap flag already set when a new DMA starts stays set; the bank is overwritten and a single swap follows.
REQ-029 dma_busy = (state != IDLE).
REQ-030 busrq is registered and glitch-free; it never deasserts before FLUSH except on reset.

Reset
REQ-031 Reset values: state=IDLE, busrq=0, dma_addr=0, wr_bank=0, pending-swap=0, scan_dout=0, dma_busy=0.
REQ-032 Reset during COPY releases the bus immediately (busrq=0) and writes nothing further.
REQ-033 Buffer RAM contents are not reset.

Structure
REQ-034 AW/DW defaults and the FSM state encoding live in a shared jtpang package.
REQ-035 One sub-module: jtframe_dual_ram, holding both banks; address MSB = bank select.

Verification
REQ-036 Basic copy: dma_go pulse, busak_n=0 two cycles later, VRAM[i]=i^8'h5A -> busrq high for 512+ pxl_cen; after the next LVBL fall, scan_addr=3 returns 8'h59.
REQ-037 Bus stall: busak_n=1 for 20 pxl_cen at dma_addr=100 -> dma_addr holds at 100 and no writes occur; final buffer matches VRAM exactly.
REQ-038 Ignored trigger: dma_go repeated at dma_addr=200 -> single transfer, busrq falls once, dma_busy width unchanged.
REQ-039 Deferred swap: LVBL falls mid-COPY -> scanner still sees the old bank; swap occurs at the following LVBL fall.
REQ-040 Reset at dma_addr=300 -> busrq=0 within one clk, wr_bank=0, no swap at the next LVBL.
REQ-041 Bank isolation: scanner reads all 512 addresses during COPY -> data equals the previous frame's table throughout.
